// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the ibus request and
// response handshake, and buffers returned instructions in an output slot
// backed by a one-deep skid register so a decode stall never loses data.
// Redirects flush the buffers. A redirect that arrives while a request is
// still outstanding lets that request finish, discards its data, and then
// fetches the new target.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall_in,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        stallI
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam logic [63:0] STEP = 64'(INSTR_BYTES);

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] req_addr_q;
  logic        out_valid_q;
  logic [63:0] out_pc_q;
  logic [31:0] out_instr_q;
  logic        skid_valid_q;
  logic [63:0] skid_pc_q;
  logic [31:0] skid_instr_q;

  logic accept;
  logic slot_free;

  // Downstream handshake: the slot is consumed when it is valid and not stalled.
  always_comb begin
    accept    = out_valid_q && !stall_in;
    slot_free = !out_valid_q || accept;
  end

  // Bus request: held stable from issue until data_ok; quiet in WAIT and reset.
  always_comb begin
    ireq_valid = !reset && (state_q != ST_WAIT);
    ireq_addr  = req_addr_q;
    stallI     = ireq_valid && !iresp_data_ok;
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  // Fetch state machine together with the PC, request address, slot and skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 64'd0;
      out_instr_q  <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 64'd0;
      skid_instr_q <= 32'd0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (redirect_valid) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            pc_q         <= redirect_pc;
            if (iresp_data_ok) begin
              // Request completed this cycle: drop it and restart right away.
              req_addr_q <= redirect_pc;
            end else begin
              // Request still outstanding: keep its address on the bus and drain.
              state_q <= ST_DISCARD;
            end
          end else if (iresp_data_ok) begin
            if (slot_free) begin
              out_valid_q <= 1'b1;
              out_pc_q    <= req_addr_q;
              out_instr_q <= iresp_data;
              pc_q        <= req_addr_q + STEP;
              req_addr_q  <= req_addr_q + STEP;
            end else begin
              // Slot is held by a stalled consumer: park the word in the skid.
              skid_valid_q <= 1'b1;
              skid_pc_q    <= req_addr_q;
              skid_instr_q <= iresp_data;
              pc_q         <= req_addr_q + STEP;
              state_q      <= ST_WAIT;
            end
          end else if (accept) begin
            out_valid_q <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            pc_q         <= redirect_pc;
            req_addr_q   <= redirect_pc;
            state_q      <= ST_FETCH;
          end else if (accept && skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_pc_q     <= skid_pc_q;
            out_instr_q  <= skid_instr_q;
            skid_valid_q <= 1'b0;
            req_addr_q   <= pc_q;
            state_q      <= ST_FETCH;
          end
        end

        ST_DISCARD: begin
          if (redirect_valid) begin
            // Newest redirect wins; the stale request keeps draining.
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            pc_q         <= redirect_pc;
            if (iresp_data_ok) begin
              req_addr_q <= redirect_pc;
              state_q    <= ST_FETCH;
            end
          end else if (iresp_data_ok) begin
            req_addr_q <= pc_q;
            state_q    <= ST_FETCH;
          end else if (accept) begin
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage. Owns the PC and drives the ibus request/response handshake.
- Buffers the returned instruction in a one-deep output slot plus a one-deep skid register, so decode stalls never drop data.
- Handles PC redirects from execute/commit. A redirect that lands while a bus request is in flight drains that request and discards its data before fetching the new target.
- Sits between the ibus and the fetch/decode pipeline register.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC of the first fetch after reset.
- INSTR_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- redirect_valid  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  64  redirect target
- stall_in  input  1  downstream cannot accept the output slot this cycle
- ireq_valid  output  1  ibus request valid
- ireq_addr  output  64  ibus request address
- iresp_data_ok  input  1  ibus response valid this cycle; completes the request
- iresp_data  input  32  instruction word
- out_valid  output  1  output slot holds an instruction
- out_pc  output  64  PC of the slot instruction
- out_instr  output  32  slot instruction
- stallI  output  1  ireq_valid && !iresp_data_ok

Behaviour:
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the in-flight request.
  - slot: out_valid, out_pc, out_instr.
  - skid: valid bit, pc, instr.
  - state: FETCH, WAIT or DISCARD.
- Reset (synchronous, takes priority over everything):
  - pc = RESET_PC, req_addr = RESET_PC, state = FETCH.
  - out_valid = 0, out_pc = 0, out_instr = 0, skid valid = 0.
  - ireq_valid is forced to 0 in every cycle where reset = 1.
  - The first request is issued in the first cycle after reset deasserts.
- Accept condition: accept = out_valid && !stall_in. A slot not accepted holds its value.
- Bus rule: once ireq_valid = 1, ireq_valid and ireq_addr stay stable until the cycle iresp_data_ok = 1. Requests are never withdrawn or altered mid-flight.
- FETCH:
  - Drives ireq_valid = 1, ireq_addr = req_addr (equals pc in this state).
  - No data_ok and no redirect: hold.
  - data_ok, no redirect, slot free (!out_valid or accept): slot <= {1, req_addr, iresp_data}; pc, req_addr <= req_addr + INSTR_BYTES; stay FETCH. Back-to-back fetches are allowed, one instruction per data_ok.
  - data_ok, no redirect, slot full and stalled: skid <= {req_addr, iresp_data}; pc <= req_addr + 4; go WAIT.
  - redirect and data_ok in the same cycle: drop the data; pc, req_addr <= redirect_pc; stay FETCH.
  - redirect without data_ok: pc <= redirect_pc; go DISCARD. req_addr is unchanged.
- WAIT:
  - ireq_valid = 0.
  - On accept: slot <= skid; skid valid <= 0; req_addr <= pc; go FETCH.
- DISCARD:
  - ireq_valid = 1, ireq_addr = old req_addr.
  - On data_ok: drop the data; req_addr <= pc; go FETCH.
  - Further redirects while in DISCARD: pc <= newest redirect_pc; stay DISCARD until data_ok.
- Redirect in any state:
  - out_valid <= 0 and skid valid <= 0 next cycle.
  - Redirect overrides stall_in and accept.
  - In WAIT: pc, req_addr <= redirect_pc; go FETCH.
- No instruction from an address fetched before a redirect may appear on out_* after the redirect cycle.
- Latency: data_ok at cycle N gives out_valid = 1 at N+1, when the slot is free.
- PC arithmetic is 64-bit unsigned and wraps modulo 2^64. There is no alignment check.

Test Plan:
- Reset, then data_ok = 1 every cycle with data = addr[31:0] and stall_in = 0 -> ireq_addr 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; out_pc follows one cycle later with out_instr = low 32 bits of out_pc.
- stall_in = 1 for 5 cycles while data_ok keeps arriving -> slot holds 0x80000000; the 0x80000004 instruction goes to skid; ireq_valid = 0 in WAIT. Release stall -> 0x80000004 then 0x80000008 delivered in order, no loss or duplication.
- Redirect to 0x80001000 while the request for 0x80000008 is in flight (data_ok 3 cycles later) -> ireq_addr stays 0x80000008 until data_ok; that data is dropped; next request is 0x80001000; out_valid = 0 in between.
- Redirect to 0x80002000 in the same cycle as data_ok -> data dropped; next-cycle ireq_addr = 0x80002000; out_valid = 0.
- Two redirects (0x100, then 0x200) during one DISCARD -> only 0x200 is fetched after the drain.
- Reset asserted mid-DISCARD -> next cycle ireq_valid = 0 and out_valid = 0; first request after deassert is 0x80000000.
